// File: rtl/rtclock_multi.sv
// rtclock_multi: {sec,nsec} time-of-day counter with trimmable fixed-point increment, disciplined to one of NUM_PPS PPS inputs.
// Latency: time registered (load visible next cycle); PPS edge accepted 3 clk after input rise (2+GLITCH_CYCLES with filter).
// Backpressure: none; all inputs are sampled every cycle. Optional macro: RTCLOCK_MULTI_GLITCH_FILTER_EN.
module rtclock_multi #(
  parameter int SEC_WIDTH     = 48,
  parameter int NUM_PPS       = 2,
  parameter int CLK_PERIOD_NS = 8,
  parameter int FRAC_BITS     = 24,
  parameter int NSEC_MODULO   = 1000000000,
  parameter int PPS_COMP_NS   = 24,
  parameter int GLITCH_CYCLES = 4,
  localparam int SEL_W = (NUM_PPS > 1) ? $clog2(NUM_PPS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PPS-1:0]   pps,
  input  logic                 sync_en,
  input  logic [SEL_W-1:0]     pps_sel,
  input  logic [FRAC_BITS:0]   incr_adj,
  input  logic                 load_valid,
  input  logic [SEC_WIDTH-1:0] load_sec,
  input  logic [29:0]          load_nsec,
  output logic [SEC_WIDTH-1:0] sec,
  output logic [29:0]          nsec,
  output logic                 stamp_valid,
  output logic [SEC_WIDTH-1:0] stamp_sec,
  output logic [29:0]          stamp_nsec,
  output logic [31:0]          last_period,
  output logic                 sync_lost
);

`ifdef RTCLOCK_MULTI_GLITCH_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif
  // Run length of synchronised-high cycles needed; a run length of 1 is a plain rising-edge detect.
  localparam int GLITCH_N = FILTER_EN ? GLITCH_CYCLES : 1;
  localparam int HI_W     = $clog2(GLITCH_N + 1);
  localparam int ACC_W    = 30 + FRAC_BITS;
  localparam logic [ACC_W:0] BASE_STEP = (ACC_W+1)'(CLK_PERIOD_NS) << FRAC_BITS;

  logic                 sync1_q, sync2_q;
  logic [HI_W-1:0]      hi_q, hi_d;
  logic [SEL_W-1:0]     sel_q;
  logic [1:0]           blank_q, blank_d;
  logic                 sen_q;
  logic [SEC_WIDTH-1:0] sec_q, sec_d, stamp_sec_q;
  logic [29:0]          nsec_q, nsec_d, stamp_nsec_q;
  logic [FRAC_BITS-1:0] frac_q, frac_d;
  logic [31:0]          cyc_q, cyc_inc, last_period_q;
  logic [1:0]           missed_q, missed_d;
  logic                 stamp_valid_q, sync_lost_q, sync_lost_d;
  logic                 edge_det, sen_rise, wrap;
  logic signed [ACC_W:0] step_s;
  logic [ACC_W:0]       step, sum;
  logic [30:0]          sum_nsec;

  // Edge qualification: blanking after a channel change, then high-run counting.
  always_comb begin
    blank_d = (pps_sel != sel_q) ? 2'd3 : ((blank_q != 2'd0) ? blank_q - 2'd1 : 2'd0);
    hi_d = hi_q;
    if (blank_q != 2'd0) begin
      // Pretend the current level has been stable, so the flush cannot look like a fresh edge.
      hi_d = sync2_q ? HI_W'(GLITCH_N) : '0;
    end else if (!sync2_q) begin
      hi_d = '0;
    end else if (hi_q != HI_W'(GLITCH_N)) begin
      hi_d = hi_q + HI_W'(1);
    end
    edge_det = (blank_q == 2'd0) && sync2_q && (hi_q == HI_W'(GLITCH_N - 1));
    sen_rise = sync_en && !sen_q;
    cyc_inc  = (cyc_q == 32'hFFFF_FFFF) ? cyc_q : cyc_q + 32'd1;
  end

  // Time next-state: load beats PPS correction, which beats the free-running advance.
  always_comb begin
    step_s   = $signed(BASE_STEP) + $signed({{(ACC_W-FRAC_BITS){incr_adj[FRAC_BITS]}}, incr_adj});
    step     = step_s[ACC_W] ? '0 : $unsigned(step_s);
    sum      = {1'b0, nsec_q, frac_q} + step;
    sum_nsec = sum[ACC_W:FRAC_BITS];
    wrap     = sum_nsec >= 31'(NSEC_MODULO);
    sec_d    = sec_q;
    nsec_d   = nsec_q;
    frac_d   = frac_q;
    missed_d = missed_q;
    if (load_valid) begin
      sec_d    = load_sec;
      nsec_d   = load_nsec;
      frac_d   = '0;
      missed_d = 2'd0;
    end else if (edge_det && sync_en) begin
      nsec_d   = 30'(PPS_COMP_NS);
      frac_d   = '0;
      missed_d = 2'd0;
      // An edge in the upper half-second means it beat the natural wrap to the new second.
      if (nsec_q >= 30'(NSEC_MODULO / 2)) sec_d = sec_q + SEC_WIDTH'(1);
    end else begin
      frac_d = sum[FRAC_BITS-1:0];
      if (wrap) begin
        nsec_d = sum_nsec[29:0] - 30'(NSEC_MODULO);
        sec_d  = sec_q + SEC_WIDTH'(1);
        if (missed_q != 2'd3) missed_d = missed_q + 2'd1;
      end else begin
        nsec_d = sum_nsec[29:0];
      end
      if (sen_rise) missed_d = 2'd0;
    end
    sync_lost_d = sync_en && (missed_d >= 2'd2);
  end

  // State registers: synchroniser, time, stamp and period measurement.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      hi_q          <= '0;
      sel_q         <= '0;
      blank_q       <= 2'd0;
      sen_q         <= 1'b0;
      sec_q         <= '0;
      nsec_q        <= '0;
      frac_q        <= '0;
      missed_q      <= 2'd0;
      cyc_q         <= '0;
      last_period_q <= '0;
      stamp_sec_q   <= '0;
      stamp_nsec_q  <= '0;
      stamp_valid_q <= 1'b0;
      sync_lost_q   <= 1'b0;
    end else begin
      sync1_q       <= pps[pps_sel];
      sync2_q       <= sync1_q;
      hi_q          <= hi_d;
      sel_q         <= pps_sel;
      blank_q       <= blank_d;
      sen_q         <= sync_en;
      sec_q         <= sec_d;
      nsec_q        <= nsec_d;
      frac_q        <= frac_d;
      missed_q      <= missed_d;
      sync_lost_q   <= sync_lost_d;
      stamp_valid_q <= edge_det;
      if (edge_det) begin
        stamp_sec_q   <= sec_q;
        stamp_nsec_q  <= nsec_q;
        last_period_q <= cyc_inc;
        cyc_q         <= '0;
      end else if (sen_rise) begin
        cyc_q <= '0;
      end else begin
        cyc_q <= cyc_inc;
      end
    end
  end

  assign sec         = sec_q;
  assign nsec        = nsec_q;
  assign stamp_valid = stamp_valid_q;
  assign stamp_sec   = stamp_sec_q;
  assign stamp_nsec  = stamp_nsec_q;
  assign last_period = last_period_q;
  assign sync_lost   = sync_lost_q;

endmodule

// File: tb/tb_rtclock_multi.sv
// tb_rtclock_multi: directed scenarios plus randomized traffic against a reference model of rtclock_multi.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Model parameters: NSEC_MODULO=1000, CLK_PERIOD_NS=8, FRAC_BITS=24, PPS_COMP_NS=24, NUM_PPS=2.
module tb_rtclock_multi;
  localparam longint ONE   = 64'd1 << 24;
  localparam longint MASK  = (64'd1 << 48) - 1;
  localparam longint MAX32 = 64'hFFFF_FFFF;

  logic               clk;
  logic               reset;
  logic [1:0]         pps;
  logic               sync_en;
  logic [0:0]         pps_sel;
  logic signed [24:0] incr_adj;
  logic               load_valid;
  logic [47:0]        load_sec;
  logic [29:0]        load_nsec;
  logic [47:0]        sec, stamp_sec;
  logic [29:0]        nsec, stamp_nsec;
  logic               stamp_valid, sync_lost;
  logic [31:0]        last_period;

  int total = 0;
  int bad   = 0;

  // reference model state
  longint m_sec, m_acc, m_cyc, m_lp, m_ssec, m_snsec, m_step, m_ns;
  int     m_missed, m_age;
  bit     m_svld, m_lost, m_senp, m_edge, m_rise, l1, l2, l3;
  logic [0:0] m_selp;

  rtclock_multi #(
    .SEC_WIDTH(48), .NUM_PPS(2), .CLK_PERIOD_NS(8), .FRAC_BITS(24),
    .NSEC_MODULO(1000), .PPS_COMP_NS(24), .GLITCH_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .pps(pps), .sync_en(sync_en), .pps_sel(pps_sel),
    .incr_adj(incr_adj), .load_valid(load_valid), .load_sec(load_sec), .load_nsec(load_nsec),
    .sec(sec), .nsec(nsec), .stamp_valid(stamp_valid), .stamp_sec(stamp_sec),
    .stamp_nsec(stamp_nsec), .last_period(last_period), .sync_lost(sync_lost)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: time kept as one integer in units of 2^-24 ns; the PPS
  // level seen at each clock is remembered, an edge counts when the level two
  // clocks back is high, three back is low, and the channel was not changed
  // during the last three clocks.
  task automatic model_step();
    if (reset) begin
      m_sec = 0; m_acc = 0; m_cyc = 0; m_lp = 0; m_ssec = 0; m_snsec = 0;
      m_missed = 0; m_svld = 0; m_lost = 0; m_senp = 0;
      l1 = 0; l2 = 0; l3 = 0; m_selp = 1'b0; m_age = 3;
    end else begin
      m_edge = l2 && !l3 && (m_age >= 3);
      m_rise = sync_en && !m_senp;
      m_step = 8 * ONE + longint'(incr_adj);
      if (m_step < 0) m_step = 0;
      m_ns = m_acc / ONE;
      if (m_edge) begin
        m_ssec = m_sec; m_snsec = m_ns; m_svld = 1;
        m_lp = (m_cyc + 1 > MAX32) ? MAX32 : m_cyc + 1;
        m_cyc = 0;
      end else begin
        m_svld = 0;
        if (m_rise) m_cyc = 0;
        else if (m_cyc < MAX32) m_cyc = m_cyc + 1;
      end
      if (load_valid) begin
        m_sec = longint'(load_sec); m_acc = longint'(load_nsec) * ONE; m_missed = 0;
      end else if (m_edge && sync_en) begin
        if (m_ns >= 500) m_sec = (m_sec + 1) & MASK;
        m_acc = 24 * ONE; m_missed = 0;
      end else begin
        m_acc = m_acc + m_step;
        if (m_acc / ONE >= 1000) begin
          m_acc = m_acc - 1000 * ONE;
          m_sec = (m_sec + 1) & MASK;
          if (m_missed < 3) m_missed = m_missed + 1;
        end
        if (m_rise) m_missed = 0;
      end
      m_lost = sync_en && (m_missed >= 2);
      m_senp = sync_en;
      if (pps_sel != m_selp) m_age = 0;
      else if (m_age < 3) m_age = m_age + 1;
      m_selp = pps_sel;
      l3 = l2; l2 = l1; l1 = pps[pps_sel];
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; pps = 2'b00; sync_en = 1'b0; pps_sel = 1'b0; incr_adj = '0;
    load_valid = 1'b0; load_sec = '0; load_nsec = '0;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    load_valid = 1'b1; load_sec = 48'd77; load_nsec = 30'd300;
    tick();
    load_valid = 1'b0; pps = 2'b01;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    total++; if (sec !== 48'd0) begin bad++; $display("FAIL reset_sec got=%0d want=0", sec); end
    total++; if (nsec !== 30'd0) begin bad++; $display("FAIL reset_nsec got=%0d want=0", nsec); end
    total++; if (stamp_valid !== 1'b0) begin bad++; $display("FAIL reset_stamp_valid got=%0b want=0", stamp_valid); end
    total++; if (stamp_sec !== 48'd0) begin bad++; $display("FAIL reset_stamp_sec got=%0d want=0", stamp_sec); end
    total++; if (stamp_nsec !== 30'd0) begin bad++; $display("FAIL reset_stamp_nsec got=%0d want=0", stamp_nsec); end
    total++; if (last_period !== 32'd0) begin bad++; $display("FAIL reset_last_period got=%0d want=0", last_period); end
    total++; if (sync_lost !== 1'b0) begin bad++; $display("FAIL reset_sync_lost got=%0b want=0", sync_lost); end
  endtask

  task automatic test_freerun();
    do_reset();
    for (int k = 1; k <= 130; k++) begin
      tick();
      total++;
      if (nsec !== 30'((8 * k) % 1000) || sec !== 48'((8 * k) / 1000)) begin
        bad++; $display("FAIL freerun k=%0d got=%0d.%0d want=%0d.%0d", k, sec, nsec, (8 * k) / 1000, (8 * k) % 1000);
      end
    end
  endtask

  task automatic test_slew();
    do_reset();
    incr_adj = 25'sd8388608;
    tick(); tick();
    total++; if (nsec !== 30'd17) begin bad++; $display("FAIL slew_2cyc got=%0d want=17", nsec); end
    repeat (115) tick();
    total++; if (sec !== 48'd0 || nsec !== 30'd994) begin bad++; $display("FAIL slew_117 got=%0d.%0d want=0.994", sec, nsec); end
    tick();
    total++; if (sec !== 48'd1 || nsec !== 30'd3) begin bad++; $display("FAIL slew_118 got=%0d.%0d want=1.3", sec, nsec); end
    do_reset();
    incr_adj = -25'sd8388608;
    tick(); tick();
    total++; if (nsec !== 30'd15) begin bad++; $display("FAIL slew_neg got=%0d want=15", nsec); end
  endtask

  task automatic test_pps_early_late();
    do_reset();
    sync_en = 1'b1;
    repeat (122) tick();
    pps = 2'b01;
    tick(); tick();
    total++; if (stamp_valid !== 1'b0) begin bad++; $display("FAIL early_too_soon got=%0b want=0", stamp_valid); end
    tick();
    total++; if (stamp_valid !== 1'b1) begin bad++; $display("FAIL early_stamp_valid got=%0b want=1", stamp_valid); end
    total++; if (stamp_nsec !== 30'd992 || stamp_sec !== 48'd0) begin bad++; $display("FAIL early_stamp got=%0d.%0d want=0.992", stamp_sec, stamp_nsec); end
    total++; if (sec !== 48'd1 || nsec !== 30'd24) begin bad++; $display("FAIL early_time got=%0d.%0d want=1.24", sec, nsec); end
    total++; if (last_period !== 32'd124) begin bad++; $display("FAIL early_period got=%0d want=124", last_period); end
    pps = 2'b00;
    repeat (122) tick();
    total++; if (sec !== 48'd2 || nsec !== 30'd0) begin bad++; $display("FAIL late_wrap got=%0d.%0d want=2.0", sec, nsec); end
    pps = 2'b01;
    repeat (3) tick();
    total++; if (sec !== 48'd2 || nsec !== 30'd24) begin bad++; $display("FAIL late_time got=%0d.%0d want=2.24", sec, nsec); end
    total++; if (stamp_nsec !== 30'd16 || stamp_sec !== 48'd2) begin bad++; $display("FAIL late_stamp got=%0d.%0d want=2.16", stamp_sec, stamp_nsec); end
    total++; if (last_period !== 32'd125) begin bad++; $display("FAIL late_period got=%0d want=125", last_period); end
    total++; if (sync_lost !== 1'b0) begin bad++; $display("FAIL late_sync_lost got=%0b want=0", sync_lost); end
  endtask

  task automatic test_channel_select();
    do_reset();
    sync_en = 1'b1; pps = 2'b10;
    repeat (5) begin
      tick();
      total++; if (stamp_valid !== 1'b0) begin bad++; $display("FAIL chsel_idle got=%0b want=0", stamp_valid); end
    end
    pps_sel = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (i == 6 || i == 12) pps = 2'b11;
      if (i == 9) pps = 2'b10;
      if (i == 15) pps = 2'b00;
      tick();
      total++; if (stamp_valid !== 1'b0) begin bad++; $display("FAIL chsel_quiet i=%0d got=%0b want=0", i, stamp_valid); end
    end
    pps = 2'b10;
    for (int i = 1; i <= 4; i++) begin
      tick();
      total++; if (stamp_valid !== (i == 3)) begin bad++; $display("FAIL chsel_rise i=%0d got=%0b want=%0b", i, stamp_valid, i == 3); end
    end
  endtask

  task automatic test_sync_loss();
    do_reset();
    sync_en = 1'b1; pps = 2'b01;
    repeat (3) tick();
    total++; if (stamp_valid !== 1'b1 || nsec !== 30'd24) begin bad++; $display("FAIL loss_first got=%0b/%0d want=1/24", stamp_valid, nsec); end
    pps = 2'b00;
    for (int t = 4; t <= 260; t++) begin
      tick();
      total++; if (sync_lost !== (t >= 250)) begin bad++; $display("FAIL loss_flag t=%0d got=%0b want=%0b", t, sync_lost, t >= 250); end
    end
    pps = 2'b01;
    repeat (3) tick();
    total++; if (sync_lost !== 1'b0) begin bad++; $display("FAIL loss_clear got=%0b want=0", sync_lost); end
    total++; if (last_period !== 32'd260) begin bad++; $display("FAIL loss_period got=%0d want=260", last_period); end
    pps = 2'b00;
    for (int t = 264; t <= 800; t++) begin
      tick();
      total++; if (sync_lost !== m_lost) begin bad++; $display("FAIL loss_sat t=%0d got=%0b want=%0b", t, sync_lost, m_lost); end
    end
    total++; if (sync_lost !== 1'b1) begin bad++; $display("FAIL loss_sat_end got=%0b want=1", sync_lost); end
  endtask

  task automatic test_load_collision();
    do_reset();
    sync_en = 1'b1; pps = 2'b01;
    tick(); tick();
    load_valid = 1'b1; load_sec = 48'd100; load_nsec = 30'd500;
    tick();
    load_valid = 1'b0;
    total++; if (sec !== 48'd100 || nsec !== 30'd500) begin bad++; $display("FAIL coll_load got=%0d.%0d want=100.500", sec, nsec); end
    total++; if (stamp_valid !== 1'b1 || stamp_sec !== 48'd0 || stamp_nsec !== 30'd16) begin
      bad++; $display("FAIL coll_stamp got=%0b %0d.%0d want=1 0.16", stamp_valid, stamp_sec, stamp_nsec);
    end
    total++; if (last_period !== 32'd2) begin bad++; $display("FAIL coll_period got=%0d want=2", last_period); end
    tick();
    total++; if (sec !== 48'd100 || nsec !== 30'd508 || stamp_valid !== 1'b0) begin
      bad++; $display("FAIL coll_next got=%0d.%0d v=%0b want=100.508 v=0", sec, nsec, stamp_valid);
    end
    load_valid = 1'b1; load_sec = 48'hFFFF_FFFF_FFFF; load_nsec = 30'd992;
    tick();
    load_valid = 1'b0;
    total++; if (sec !== 48'hFFFF_FFFF_FFFF || nsec !== 30'd992) begin bad++; $display("FAIL secwrap_load got=%0h.%0d want=ffffffffffff.992", sec, nsec); end
    tick();
    total++; if (sec !== 48'd0 || nsec !== 30'd0) begin bad++; $display("FAIL secwrap got=%0h.%0d want=0.0", sec, nsec); end
  endtask

  task automatic test_random();
    do_reset();
    sync_en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) pps[0] = ~pps[0];
      if ($urandom_range(0, 39) == 0) pps[1] = ~pps[1];
      if ($urandom_range(0, 299) == 0) pps_sel = ~pps_sel;
      if ($urandom_range(0, 699) == 0) sync_en = ~sync_en;
      if ($urandom_range(0, 199) == 0) incr_adj = 25'($urandom);
      load_valid = ($urandom_range(0, 399) == 0);
      load_sec   = {16'($urandom), $urandom};
      load_nsec  = 30'($urandom_range(0, 999));
      tick();
      total++; if (sec !== m_sec[47:0]) begin bad++; $display("FAIL rand_sec i=%0d got=%0d want=%0d", i, sec, m_sec[47:0]); end
      total++; if (nsec !== 30'(m_acc / ONE)) begin bad++; $display("FAIL rand_nsec i=%0d got=%0d want=%0d", i, nsec, m_acc / ONE); end
      total++; if (stamp_valid !== m_svld) begin bad++; $display("FAIL rand_stamp_valid i=%0d got=%0b want=%0b", i, stamp_valid, m_svld); end
      total++; if (stamp_sec !== m_ssec[47:0]) begin bad++; $display("FAIL rand_stamp_sec i=%0d got=%0d want=%0d", i, stamp_sec, m_ssec[47:0]); end
      total++; if (stamp_nsec !== m_snsec[29:0]) begin bad++; $display("FAIL rand_stamp_nsec i=%0d got=%0d want=%0d", i, stamp_nsec, m_snsec[29:0]); end
      total++; if (last_period !== m_lp[31:0]) begin bad++; $display("FAIL rand_period i=%0d got=%0d want=%0d", i, last_period, m_lp[31:0]); end
      total++; if (sync_lost !== m_lost) begin bad++; $display("FAIL rand_sync_lost i=%0d got=%0b want=%0b", i, sync_lost, m_lost); end
    end
    load_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_freerun();
    test_slew();
    test_pps_early_late();
    test_channel_select();
    test_sync_loss();
    test_load_collision();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
